m107_palette_mixer: RTL and testbench

//  Final video stage after the GA23 tilemap block. Merges GA23 tile pixel (color/prio) with sprite pixel,

---
 rtl/m107_video_pkg.sv | 21 ++
 rtl/m107_palette_ram.sv | 55 +++++
 rtl/m107_palette_mixer.sv | 216 +++++++++++++++++++++
 tb/tb_m107_palette_mixer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/m107_video_pkg.sv
// m107_video_pkg: shared types and constants for the M107 palette mixer.
package m107_video_pkg;

   localparam int PAL_ENTRIES = 2048;
   localparam int PIX_LATENCY = 2;

   // Palette entry layout: x BBBBB GGGGG RRRRR
   typedef struct packed {
      logic       unused;
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } pal_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } cpu_fsm_t;

endpackage

// File: rtl/m107_palette_ram.sv
// m107_palette_ram: true dual-port palette RAM, 2**AW x 16.
// Port A is the video read port, port B the CPU port with byte-enable writes.
// Both ports are read-first: a read and a write to the same word in one clock
// return the old contents.
// Port B readback exists only when M107_PAL_READBACK_EN is defined; otherwise
// port B is write-only.
module m107_palette_ram
   import m107_video_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          i_en_a,
   input  logic [AW-1:0] i_addr_a,
   output logic [15:0]   o_q_a,
   input  logic          i_en_b,
   input  logic          i_we_b,
   input  logic [1:0]    i_be_b,
   input  logic [AW-1:0] i_addr_b,
   input  logic [15:0]   i_d_b
`ifdef M107_PAL_READBACK_EN
   ,
   output logic [15:0]   o_q_b
`endif
);

   logic [15:0] r_mem [2**AW];

   // Video read port: registered read, advances only when enabled.
   // NOTE: the array has no reset; contents must survive reset and a reset
   // would stop the tools from mapping it onto block RAM.
   always_ff @(posedge clk) begin
      if (i_en_a) begin
         o_q_a <= r_mem[i_addr_a];
      end
   end

   // CPU write port with independent byte lanes.
   always_ff @(posedge clk) begin
      if (i_en_b && i_we_b) begin
         if (i_be_b[0]) r_mem[i_addr_b][7:0]  <= i_d_b[7:0];
         if (i_be_b[1]) r_mem[i_addr_b][15:8] <= i_d_b[15:8];
      end
   end

`ifdef M107_PAL_READBACK_EN
   // CPU read port: samples the pre-write contents.
   always_ff @(posedge clk) begin
      if (i_en_b) begin
         o_q_b <= r_mem[i_addr_b];
      end
   end
`endif

endmodule

// File: rtl/m107_palette_mixer.sv
// m107_palette_mixer: final video stage. Picks tile or sprite pixel, looks
// it up in palette RAM, and emits RGB with delay-matched sync/blank signals.
// Also owns the CPU side of the palette RAM with a two-clock busy handshake.
// Define M107_PAL_READBACK_EN to enable CPU readback; otherwise i_pal_rd
// still runs the handshake but o_cpu_dout stays 0.
module m107_palette_mixer
   import m107_video_pkg::*;
#(
   parameter int PAL_AW = 11,
   parameter int OUT_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_ce_pix,
   input  logic [PAL_AW-1:0] i_tile_color,
   input  logic              i_tile_prio,
   input  logic [PAL_AW-1:0] i_spr_color,
   input  logic              i_spr_prio,
   input  logic              i_hblank,
   input  logic              i_vblank,
   input  logic              i_hsync,
   input  logic              i_vsync,
   input  logic              i_color_blank,
   input  logic              i_pal_cs,
   input  logic              i_pal_rd,
   input  logic              i_pal_wr,
   input  logic [PAL_AW-1:0] i_addr,
   input  logic [1:0]        i_cpu_be,
   input  logic [15:0]       i_cpu_din,
   output logic [15:0]       o_cpu_dout,
   output logic              o_busy,
   output logic [OUT_W-1:0]  o_red,
   output logic [OUT_W-1:0]  o_green,
   output logic [OUT_W-1:0]  o_blue,
   output logic              o_hblank,
   output logic              o_vblank,
   output logic              o_hsync,
   output logic              o_vsync
);

   localparam int REP_N = (OUT_W + 4) / 5;

   // Widen a 5-bit channel by repeating its MSBs into the low bits.
   function automatic logic [OUT_W-1:0] expand(input logic [4:0] c);
      logic [5*REP_N-1:0] rep;
      rep = {REP_N{c}};
      return rep[5*REP_N-1 -: OUT_W];
   endfunction

   // ---------------- Mix ----------------
   logic              w_tile_op;
   logic              w_spr_op;
   logic              w_spr_win;
   logic [PAL_AW-1:0] w_index;

   assign w_tile_op = |i_tile_color[3:0];
   assign w_spr_op  = |i_spr_color[3:0];
   assign w_spr_win = w_spr_op && (i_spr_prio || !i_tile_prio || !w_tile_op);
   assign w_index   = w_spr_win ? i_spr_color : i_tile_color;

   // ---------------- Palette RAM ----------------
   logic [15:0]       w_ram_q_a;
   pal_entry_t        w_entry;
   logic              w_unused_bit15;
   logic              w_ram_en_b;
   logic              w_ram_we_b;

   cpu_fsm_t          r_state;
   cpu_fsm_t          w_state_nxt;
   logic              r_req_prev;
   logic              r_is_wr;
   logic [1:0]        r_be;
   logic [15:0]       r_din;
   logic [PAL_AW-1:0] r_addr;

`ifdef M107_PAL_READBACK_EN
   logic [15:0]       w_ram_q_b;
`endif

   // The write is gated by reset so an access cut short by reset never lands.
   assign w_ram_en_b = (r_state == ACCESS) && reset_n;
   assign w_ram_we_b = w_ram_en_b && r_is_wr;

   m107_palette_ram #(.AW(PAL_AW)) u_ram (
      .clk      (clk),
      .i_en_a   (i_ce_pix),
      .i_addr_a (w_index),
      .o_q_a    (w_ram_q_a),
      .i_en_b   (w_ram_en_b),
      .i_we_b   (w_ram_we_b),
      .i_be_b   (r_be),
      .i_addr_b (r_addr),
      .i_d_b    (r_din)
`ifdef M107_PAL_READBACK_EN
      ,
      .o_q_b    (w_ram_q_b)
`endif
   );

   assign w_entry        = pal_entry_t'(w_ram_q_a);
   assign w_unused_bit15 = w_entry.unused;

   // ---------------- Video pipeline ----------------
   logic r_hb0, r_vb0, r_hs0, r_vs0, r_blank0;
   logic [OUT_W-1:0] r_red, r_green, r_blue;
   logic r_hb1, r_vb1, r_hs1, r_vs1;

   // Stage 0: capture timing alongside the RAM address (RAM holds the index).
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hb0    <= 1'b0;
         r_vb0    <= 1'b0;
         r_hs0    <= 1'b0;
         r_vs0    <= 1'b0;
         r_blank0 <= 1'b0;
      end else if (i_ce_pix) begin
         r_hb0    <= i_hblank;
         r_vb0    <= i_vblank;
         r_hs0    <= i_hsync;
         r_vs0    <= i_vsync;
         r_blank0 <= i_color_blank;
      end
   end

   // Stage 1: expand the palette entry to RGB and forward delayed timing.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hb1   <= 1'b0;
         r_vb1   <= 1'b0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
      end else if (i_ce_pix) begin
         r_red   <= r_blank0 ? '0 : expand(w_entry.r);
         r_green <= r_blank0 ? '0 : expand(w_entry.g);
         r_blue  <= r_blank0 ? '0 : expand(w_entry.b);
         r_hb1   <= r_hb0;
         r_vb1   <= r_vb0;
         r_hs1   <= r_hs0;
         r_vs1   <= r_vs0;
      end
   end

   assign o_red    = r_red;
   assign o_green  = r_green;
   assign o_blue   = r_blue;
   assign o_hblank = r_hb1;
   assign o_vblank = r_vb1;
   assign o_hsync  = r_hs1;
   assign o_vsync  = r_vs1;

   // ---------------- CPU access FSM ----------------
   logic w_req;
   logic w_start;

   assign w_req   = i_pal_cs && (i_pal_rd || i_pal_wr);
   assign w_start = w_req && !r_req_prev;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic: one access per strobe edge, fixed two-clock busy.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Edge detector and request capture; held strobes start only one access.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_req_prev <= 1'b0;
         r_is_wr    <= 1'b0;
         r_be       <= '0;
         r_din      <= '0;
         r_addr     <= '0;
      end else begin
         r_req_prev <= w_req;
         if (r_state == IDLE && w_start) begin
            r_is_wr <= i_pal_wr;
            r_be    <= i_cpu_be;
            r_din   <= i_cpu_din;
            r_addr  <= i_addr;
         end
      end
   end

   assign o_busy = (r_state != IDLE);

`ifdef M107_PAL_READBACK_EN
   logic [15:0] r_cpu_dout;

   // Read data is latched as the access completes; writes leave it alone.
   always_ff @(posedge clk) begin
      if (!reset_n)                        r_cpu_dout <= '0;
      else if (r_state == DONE && !r_is_wr) r_cpu_dout <= w_ram_q_b;
   end

   assign o_cpu_dout = r_cpu_dout;
`else
   assign o_cpu_dout = '0;
`endif

endmodule

// File: tb/tb_m107_palette_mixer.sv
// Directed bench for m107_palette_mixer: CPU writes/reads, priority mixing,
// pipeline latency, blanking, reset mid-access and pixel-enable hold.
module tb_m107_palette_mixer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce_pix;
   logic [10:0] tile_color, spr_color, addr;
   logic        tile_prio, spr_prio;
   logic        hblank_in, vblank_in, hsync_in, vsync_in, color_blank_in;
   logic        pal_cs, pal_rd, pal_wr;
   logic [1:0]  cpu_be;
   logic [15:0] cpu_din, cpu_dout;
   logic        busy;
   logic [7:0]  red, green, blue;
   logic        hblank, vblank, hsync, vsync;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   m107_palette_mixer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_ce_pix      (ce_pix),
      .i_tile_color  (tile_color),
      .i_tile_prio   (tile_prio),
      .i_spr_color   (spr_color),
      .i_spr_prio    (spr_prio),
      .i_hblank      (hblank_in),
      .i_vblank      (vblank_in),
      .i_hsync       (hsync_in),
      .i_vsync       (vsync_in),
      .i_color_blank (color_blank_in),
      .i_pal_cs      (pal_cs),
      .i_pal_rd      (pal_rd),
      .i_pal_wr      (pal_wr),
      .i_addr        (addr),
      .i_cpu_be      (cpu_be),
      .i_cpu_din     (cpu_din),
      .o_cpu_dout    (cpu_dout),
      .o_busy        (busy),
      .o_red         (red),
      .o_green       (green),
      .o_blue        (blue),
      .o_hblank      (hblank),
      .o_vblank      (vblank),
      .o_hsync       (hsync),
      .o_vsync       (vsync)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rgb(input string tag, input logic [23:0] exp);
      check(tag, 32'({red, green, blue}), 32'(exp));
   endtask

   // One CPU access; busy must be high for exactly the two clocks after start.
   task automatic cpu_op(input logic wr, input logic [10:0] a, input logic [15:0] d,
                         input logic [1:0] be, input string tag);
      pal_cs  = 1'b1;
      pal_wr  = wr;
      pal_rd  = !wr;
      addr    = a;
      cpu_din = d;
      cpu_be  = be;
      tick();
      check({tag, " busy1"}, 32'(busy), 32'd1);
      pal_cs = 1'b0;
      pal_wr = 1'b0;
      pal_rd = 1'b0;
      tick();
      check({tag, " busy2"}, 32'(busy), 32'd1);
      tick();
      check({tag, " busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic pixel(input logic [10:0] t, input logic tp, input logic [10:0] s, input logic sp);
      tile_color = t;
      tile_prio  = tp;
      spr_color  = s;
      spr_prio   = sp;
   endtask

   initial begin
      int          busy_cnt;
      logic [15:0] exp_rd;

      reset_n = 1'b0;  ce_pix = 1'b1;
      pixel(11'h000, 1'b0, 11'h000, 1'b0);
      hblank_in = 1'b0; vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      color_blank_in = 1'b0;
      pal_cs = 1'b0; pal_rd = 1'b0; pal_wr = 1'b0;
      addr = '0; cpu_be = '0; cpu_din = '0;
      tick();
      tick();
      check_rgb("reset rgb", 24'h000000);
      check("reset busy", 32'(busy), 32'd0);
      check("reset dout", 32'(cpu_dout), 32'd0);
      check("reset timing", 32'({hblank, vblank, hsync, vsync}), 32'd0);
      reset_n = 1'b1;
      tick();

      // Test 1: magenta at 0x005, looked up through the tile path.
      cpu_op(1'b1, 11'h005, 16'h7C1F, 2'b11, "wr005");
      cpu_op(1'b1, 11'h012, 16'h03E0, 2'b11, "wr012");
      cpu_op(1'b1, 11'h421, 16'h001F, 2'b11, "wr421");
      cpu_op(1'b1, 11'h433, 16'h7C00, 2'b11, "wr433");
      pixel(11'h005, 1'b0, 11'h000, 1'b0);
      tick();
      tick();
      check_rgb("t1 magenta", 24'hFF00FF);

      // Test 2: priority between two opaque pixels.
      pixel(11'h012, 1'b1, 11'h421, 1'b0);
      tick(); tick();
      check_rgb("t2 tile prio", 24'h00FF00);
      pixel(11'h012, 1'b1, 11'h421, 1'b1);
      tick(); tick();
      check_rgb("t2 spr prio", 24'hFF0000);
      pixel(11'h012, 1'b0, 11'h421, 1'b0);
      tick(); tick();
      check_rgb("t2 tile low prio", 24'hFF0000);

      // Test 3: transparent high-priority tile loses to sprite.
      pixel(11'h430, 1'b1, 11'h433, 1'b0);
      tick(); tick();
      check_rgb("t3 transparent tile", 24'h0000FF);

      // Test 4: blank and hsync on one pixel, seen exactly two ce_pix later.
      pixel(11'h005, 1'b0, 11'h000, 1'b0);
      tick();
      color_blank_in = 1'b1; hsync_in = 1'b1; hblank_in = 1'b1;
      tick();
      check_rgb("t4 pre", 24'hFF00FF);
      check("t4 pre sync", 32'({hblank, hsync}), 32'd0);
      color_blank_in = 1'b0; hsync_in = 1'b0; hblank_in = 1'b0;
      tick();
      check_rgb("t4 blank", 24'h000000);
      check("t4 sync", 32'({hblank, hsync}), 32'd3);
      tick();
      check_rgb("t4 post", 24'hFF00FF);
      check("t4 post sync", 32'({hblank, hsync}), 32'd0);

      // Test 5: byte-enable write then readback; held read starts once.
      cpu_op(1'b1, 11'h100, 16'hFFFF, 2'b11, "wr100a");
      cpu_op(1'b1, 11'h100, 16'h1234, 2'b01, "wr100b");
      cpu_op(1'b0, 11'h100, 16'h0000, 2'b00, "rd100");
`ifdef M107_PAL_READBACK_EN
      exp_rd = 16'hFF34;
`else
      exp_rd = 16'h0000;
`endif
      check("t5 readback", 32'(cpu_dout), 32'(exp_rd));
      pixel(11'h100, 1'b0, 11'h420, 1'b1);
      tick(); tick();
      check_rgb("t5 merged entry", 24'hA5CEFF);

      pal_cs = 1'b1; pal_rd = 1'b1; addr = 11'h005;
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) busy_cnt++;
      end
      pal_cs = 1'b0; pal_rd = 1'b0;
      check("t5 held rd busy clocks", 32'(busy_cnt), 32'd2);
`ifdef M107_PAL_READBACK_EN
      exp_rd = 16'h7C1F;
`else
      exp_rd = 16'h0000;
`endif
      check("t5 held rd data", 32'(cpu_dout), 32'(exp_rd));
      tick();

      // Test 6: reset during the ACCESS clock of a write.
      pixel(11'h005, 1'b0, 11'h000, 1'b0);
      tick(); tick();
      check_rgb("t6 before", 24'hFF00FF);
      pal_cs = 1'b1; pal_wr = 1'b1; addr = 11'h005; cpu_din = 16'h0000; cpu_be = 2'b11;
      tick();
      check("t6 busy access", 32'(busy), 32'd1);
      reset_n = 1'b0; pal_cs = 1'b0; pal_wr = 1'b0;
      tick();
      check("t6 busy reset", 32'(busy), 32'd0);
      check_rgb("t6 rgb reset", 24'h000000);
      check("t6 dout reset", 32'(cpu_dout), 32'd0);
      reset_n = 1'b1;
      tick(); tick();
      check_rgb("t6 write dropped", 24'hFF00FF);

      ce_pix = 1'b0;
      pixel(11'h012, 1'b1, 11'h000, 1'b0);
      hsync_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_rgb("t6 hold rgb", 24'hFF00FF);
         check("t6 hold sync", 32'(hsync), 32'd0);
      end
      ce_pix = 1'b1;
      hsync_in = 1'b0;
      tick(); tick();
      check_rgb("t6 resume", 24'h00FF00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
